// File: rtl/fp8_pkg.sv
// fp8 shared definitions: field widths, fixed-point format, FSM states.
package fp8_pkg;

  localparam int EXP_W = 4;
  localparam int MAN_W = 3;
  localparam int BIAS = 7;
  localparam logic [EXP_W-1:0] EXP_SPECIAL = 4'hF;

  localparam int OUT_W = 19;
  localparam int FRAC_W = 10;

  localparam logic [OUT_W-1:0] POS_SAT = 19'h3FFFF;
  localparam logic [OUT_W-1:0] NEG_SAT = 19'h40000;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    SIGN,
    DONE
  } state_e;

endpackage

// File: rtl/fp8_unpack.sv
// fp8 field splitter and classifier, purely combinational.
module fp8_unpack
  import fp8_pkg::*;
(
  input  logic [EXP_W+MAN_W:0] fp_i,
  output logic                 sign_o,
  output logic [EXP_W-1:0]     exp_o,
  output logic [MAN_W:0]       man_o,
  output logic                 is_zero_o,
  output logic                 is_inf_o,
  output logic                 is_nan_o
);

  logic [MAN_W-1:0] frac;

  assign sign_o = fp_i[EXP_W+MAN_W];
  assign exp_o  = fp_i[EXP_W+MAN_W-1:MAN_W];
  assign frac   = fp_i[MAN_W-1:0];
  assign man_o  = {1'b1, frac};

  // Both signed zeros collapse to zero; no denormals exist.
  assign is_zero_o = (fp_i[EXP_W+MAN_W-1:0] == '0);
  assign is_inf_o  = (exp_o == EXP_SPECIAL) && (frac == '0);
  assign is_nan_o  = (exp_o == EXP_SPECIAL) && (frac != '0);

endmodule

// File: rtl/fp8_to_fixed.sv
// Iterative fp8 -> 19-bit Q8.10 converter, one left shift per cycle.
module fp8_to_fixed
  import fp8_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_W-1:0]       out_data,
  output logic                   out_inf,
  output logic                   out_nan
);

  state_e           state_q, state_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [EXP_W-1:0] cnt_q, cnt_d;
  logic             sign_q, sign_d;
  logic             zero_q, zero_d;
  logic             inf_q, inf_d;
  logic             nan_q, nan_d;
  logic             oinf_q, oinf_d;
  logic             onan_q, onan_d;

  logic             u_sign;
  logic [EXP_W-1:0] u_exp;
  logic [MAN_W:0]   u_man;
  logic             u_zero;
  logic             u_inf;
  logic             u_nan;

  fp8_unpack u_unpack (
    .fp_i      (in_data),
    .sign_o    (u_sign),
    .exp_o     (u_exp),
    .man_o     (u_man),
    .is_zero_o (u_zero),
    .is_inf_o  (u_inf),
    .is_nan_o  (u_nan)
  );

  assign in_ready  = ena && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_data  = acc_q;
  assign out_inf   = oinf_q;
  assign out_nan   = onan_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sign_d  = sign_q;
    zero_d  = zero_q;
    inf_d   = inf_q;
    nan_d   = nan_q;
    oinf_d  = oinf_q;
    onan_d  = onan_q;
    if (ena) begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            sign_d  = u_sign;
            acc_d   = {{(OUT_W-MAN_W-1){1'b0}}, u_man};
            cnt_d   = u_exp;
            zero_d  = u_zero;
            inf_d   = u_inf;
            nan_d   = u_nan;
            oinf_d  = 1'b0;
            onan_d  = 1'b0;
            // Specials carry e=15 but never shift.
            if (!u_zero && !u_inf && !u_nan && u_exp != '0)
              state_d = SHIFT;
            else
              state_d = SIGN;
          end
        end
        SHIFT: begin
          acc_d = acc_q << 1;
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1)
            state_d = SIGN;
        end
        SIGN: begin
          unique case (1'b1)
            zero_q: acc_d = '0;
            nan_q: begin
              acc_d  = '0;
              onan_d = 1'b1;
            end
            inf_q: begin
              acc_d  = sign_q ? NEG_SAT : POS_SAT;
              oinf_d = 1'b1;
            end
            default: begin
              if (sign_q)
                acc_d = -acc_q;
            end
          endcase
          state_d = DONE;
        end
        DONE: begin
          if (out_ready)
            state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sign_q  <= 1'b0;
      zero_q  <= 1'b0;
      inf_q   <= 1'b0;
      nan_q   <= 1'b0;
      oinf_q  <= 1'b0;
      onan_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sign_q  <= sign_d;
      zero_q  <= zero_d;
      inf_q   <= inf_d;
      nan_q   <= nan_d;
      oinf_q  <= oinf_d;
      onan_q  <= onan_d;
    end
  end

endmodule

// File: doc/fp8_to_fixed.md
# fp8_to_fixed

Iterative decoder that turns one 8-bit float (1 sign, 4 exponent, 3 mantissa, hidden one) into an exact 19-bit two's-complement fixed-point value. It is the reverse direction of the fp8 adder datapath: adder results or host-supplied fp8 words feed in, and integer-domain consumers read the fixed-point result. A valid/ready handshake on both sides lets it sit between the adder output register and downstream logic. It uses one shift per cycle, so the area stays small.

## Interface
- Parameters: none. All widths are fixed by the shared package.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  synchronous reset, active-high despite its name, sampled on clk.
- ena  in  1  global enable. While low, all state and outputs freeze and in_ready is 0.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts in_data this cycle.
- in_data  in  8  fp8 word: [7] sign, [6:3] exponent, [2:0] mantissa.
- out_valid  out  1  out_data and the flags are valid.
- out_ready  in  1  consumer takes the result this cycle.
- out_data  out  19  signed fixed-point result, value = out_data * 2^-10.
- out_inf  out  1  input was infinity.
- out_nan  out  1  input was NaN.

## Operation
- Encoding: bias 7, value = 1.mmm * 2^(e-7) for e in 0..14.
  - 0x00 and 0x80 mean zero.
  - e=15 with m=0 means ±inf; e=15 with m≠0 means NaN.
  - There are no denormals.
- Magnitude is M<<e with M={1,mmm}, so the maximum is 15<<14 = 0x3C000. This is exact, with no rounding.
- FSM states: IDLE, SHIFT, SIGN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready, latch sign, load acc={15'b0,M}, set cnt=e, and classify the input.
  - Normal input with e≠0: go to SHIFT.
  - Zero, special, or e=0: go to SIGN.
- SHIFT: each cycle acc<<=1 and cnt-=1. When cnt reaches 0 (the shift that makes it 0 is included), go to SIGN.
- SIGN: one cycle, always taken.
  - Normal input with sign=1: acc = -acc (19-bit two's complement).
  - Zero: acc=0.
  - Inf: acc = sign ? 19'h40000 : 19'h3FFFF, out_inf=1.
  - NaN: acc=0, out_nan=1.
  - Go to DONE.
- DONE: out_valid=1 and out_data=acc. On out_ready, go to IDLE. There is no bypass: in_ready stays 0 until IDLE.
- Only one item is in flight at a time.
- out_data, out_inf and out_nan hold stable while out_valid=1.
- Reset values: state=IDLE, acc=0, cnt=0, in_ready=1 when ena=1, out_valid=0, out_data=0, out_inf=0, out_nan=0.
- Reset mid-operation abandons the item. The block is in IDLE on the next cycle with all outputs at their reset values.
- ena low mid-operation: the FSM freezes in place. out_valid keeps its value, but no handshake completes while ena=0.
- in_valid during non-IDLE states is ignored.

## Timing
- Cycle 0 is the accept edge. Normal input with e≥1: e cycles in SHIFT, one in SIGN, and out_valid=1 from cycle e+2.
- Zero, special, or e=0: out_valid=1 from cycle 2.
- Minimum item period is latency+1 cycles, because DONE→IDLE costs one cycle.
- All outputs are registered. in_ready is combinational from state and ena only, never from in_valid.

## Structure
- Package fp8_pkg holds:
  - field widths (EXP_W=4, MAN_W=3), BIAS=7, EXP_SPECIAL=4'hF;
  - OUT_W=19, FRAC_W=10;
  - POS_SAT=19'h3FFFF, NEG_SAT=19'h40000;
  - the state enum (IDLE, SHIFT, SIGN, DONE).
- Sub-module fp8_unpack is combinational. It splits sign/exp/mant, forms M, and drives the is_zero, is_inf and is_nan class bits. It is reusable by the adder.
- The top level holds the FSM, acc and cnt.

## Test plan
- 0x3F (e=7, m=7) with out_ready=1 → out_data=0x00780 at cycle 9, flags 0, in_ready back to 1 at cycle 10.
- 0xC0 (−1.0 * 2^1) → out_data=0x7F800 at cycle 10; 0x77 → 0x3C000 at cycle 16.
- 0x00 → 0 at cycle 2; 0x01 (e=0) → 0x00009 at cycle 2.
- Specials:
  - 0x78 → 0x3FFFF, out_inf=1.
  - 0xF8 → 0x40000, out_inf=1.
  - 0x79 → 0, out_nan=1.
  - All three arrive at cycle 2.
- Backpressure: hold out_ready=0 for 5 cycles in DONE → out_data stable and in_valid ignored. Also drop ena for 3 cycles mid-SHIFT → latency extends by exactly 3.
- Assert rst_n during SHIFT for 0x77 → next cycle IDLE with out_valid=0. A following 0x3F then decodes normally.
